// File: rtl/fpu16_result_fifo.sv
// rtl/fpu16_result_fifo.sv - in-order result buffer between the FP16 FPU and writeback
//
// Purpose:
//   Captures each FPU result (op, value, condition codes, comparison flags) on a
//   valid/ready handshake into a DEPTH-entry circular FIFO. It presents the head
//   entry to the writeback consumer and keeps sticky condition codes so software
//   can poll for exceptions.
//
// Ports:
//   clock, reset          - rising-edge clock; asynchronous active-high reset
//   inValid / inReady     - producer handshake (inReady = !full)
//   inOp, inResult,
//   inCondCodes, inComps  - result fields captured on a push
//   outValid / outReady   - consumer handshake (outValid = !empty)
//   outOp, outResult,
//   outCondCodes, outComps- head entry fields, forced to zero while empty
//   count                 - current occupancy, 0..DEPTH
//   clearSticky           - clears the sticky flags (a same-cycle push still lands)
//   stickyCondCodes       - OR of condition codes of all pushes since reset/clear

module fpu16_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [1:0]       inOp,
  input  logic [15:0]      inResult,
  input  logic [3:0]       inCondCodes,
  input  logic [2:0]       inComps,
  output logic             outValid,
  input  logic             outReady,
  output logic [1:0]       outOp,
  output logic [15:0]      outResult,
  output logic [3:0]       outCondCodes,
  output logic [2:0]       outComps,
  output logic [CNT_W-1:0] count,
  input  logic             clearSticky,
  output logic [3:0]       stickyCondCodes
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 25;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wp;
  logic [PTR_W-1:0]   rp;
  logic [CNT_W-1:0]   occupancy;
  logic [3:0]         sticky;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] headEntry;

  // Full/empty come from the registered count only, so neither handshake
  // output depends combinationally on inValid or outReady. A pop on a full
  // cycle does not open a slot until the following cycle.
  assign full  = (occupancy == CNT_W'(DEPTH));
  assign empty = (occupancy == '0);
  assign push  = inValid & ~full;
  assign pop   = outReady & ~empty;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wp] <= {inOp, inResult, inCondCodes, inComps};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      occupancy <= '0;
      sticky    <= '0;
    end else begin
      if (push) begin
        wp <= wp + PTR_W'(1);
      end
      if (pop) begin
        rp <= rp + PTR_W'(1);
      end
      if (push && !pop) begin
        occupancy <= occupancy + CNT_W'(1);
      end else if (pop && !push) begin
        occupancy <= occupancy - CNT_W'(1);
      end
      // Clear takes effect before the OR, so clear+push leaves only the new codes.
      sticky <= (clearSticky ? 4'h0 : sticky) | (push ? inCondCodes : 4'h0);
    end
  end

  // Head is masked to zero while empty so stale storage never leaks out.
  assign headEntry = empty ? '0 : mem[rp];

  assign inReady         = ~full;
  assign outValid        = ~empty;
  assign outOp           = headEntry[24:23];
  assign outResult       = headEntry[22:7];
  assign outCondCodes    = headEntry[6:3];
  assign outComps        = headEntry[2:0];
  assign count           = occupancy;
  assign stickyCondCodes = sticky;

endmodule

// File: tb/tb_fpu16_result_fifo.sv
// tb/tb_fpu16_result_fifo.sv - directed self-checking bench for fpu16_result_fifo

module tb_fpu16_result_fifo;

  logic        clock;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [1:0]  inOp;
  logic [15:0] inResult;
  logic [3:0]  inCondCodes;
  logic [2:0]  inComps;
  logic        outValid;
  logic        outReady;
  logic [1:0]  outOp;
  logic [15:0] outResult;
  logic [3:0]  outCondCodes;
  logic [2:0]  outComps;
  logic [2:0]  count;
  logic        clearSticky;
  logic [3:0]  stickyCondCodes;

  int checks = 0;
  int errors = 0;

  fpu16_result_fifo #(.DEPTH(4), .CNT_W(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .inValid        (inValid),
    .inReady        (inReady),
    .inOp           (inOp),
    .inResult       (inResult),
    .inCondCodes    (inCondCodes),
    .inComps        (inComps),
    .outValid       (outValid),
    .outReady       (outReady),
    .outOp          (outOp),
    .outResult      (outResult),
    .outCondCodes   (outCondCodes),
    .outComps       (outComps),
    .count          (count),
    .clearSticky    (clearSticky),
    .stickyCondCodes(stickyCondCodes)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pushOne(input logic [1:0] op, input logic [15:0] res, input logic [3:0] cc, input logic [2:0] cmp);
    inValid     = 1'b1;
    inOp        = op;
    inResult    = res;
    inCondCodes = cc;
    inComps     = cmp;
    step();
    inValid     = 1'b0;
  endtask

  logic [15:0] fillVals [4];

  initial begin
    reset = 1'b1; inValid = 1'b0; inOp = 2'd0; inResult = 16'h0;
    inCondCodes = 4'h0; inComps = 3'b000; outReady = 1'b0; clearSticky = 1'b0;
    #2;
    chk("rst_outValid", 32'(outValid), 32'd0);
    chk("rst_inReady",  32'(inReady),  32'd1);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_sticky",   32'(stickyCondCodes), 32'd0);
    chk("rst_outResult", 32'(outResult), 32'd0);
    step();
    step();
    reset = 1'b0;

    // Single push and pop
    pushOne(2'd0, 16'h4200, 4'h0, 3'b001);
    chk("single_outValid", 32'(outValid), 32'd1);
    chk("single_outResult", 32'(outResult), 32'h4200);
    chk("single_outComps", 32'(outComps), 32'h1);
    chk("single_outOp", 32'(outOp), 32'd0);
    chk("single_count", 32'(count), 32'd1);
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    chk("single_pop_outValid", 32'(outValid), 32'd0);
    chk("single_pop_fields", 32'({outOp, outResult, outCondCodes, outComps}), 32'd0);
    chk("single_pop_count", 32'(count), 32'd0);

    // Fill to full, reject fifth, drain in order
    fillVals[0] = 16'h3C00; fillVals[1] = 16'h4000; fillVals[2] = 16'h4200; fillVals[3] = 16'h4400;
    for (int i = 0; i < 4; i++) pushOne(2'(i + 1), fillVals[i], 4'h0, 3'b010);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_inReady", 32'(inReady), 32'd0);
    pushOne(2'd1, 16'h4500, 4'h0, 3'b000);
    chk("fifth_count", 32'(count), 32'd4);
    chk("fifth_head", 32'(outResult), 32'h3C00);
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_%0d_result", i), 32'(outResult), 32'(fillVals[i]));
      chk($sformatf("drain_%0d_op", i), 32'(outOp), 32'((i + 1) % 4));
      step();
    end
    outReady = 1'b0;
    chk("drain_outValid", 32'(outValid), 32'd0);
    chk("drain_count", 32'(count), 32'd0);

    // Sustained push/pop at count=2 across pointer wraps
    pushOne(2'd0, 16'h0100, 4'h0, 3'b000);
    pushOne(2'd0, 16'h0101, 4'h0, 3'b000);
    for (int i = 0; i < 10; i++) begin
      inValid = 1'b1; inResult = 16'(16'h0102 + i); outReady = 1'b1;
      chk($sformatf("stream_%0d_head", i), 32'(outResult), 32'(16'h0100 + i));
      step();
      chk($sformatf("stream_%0d_count", i), 32'(count), 32'd2);
    end
    inValid = 1'b0;
    chk("stream_tail0", 32'(outResult), 32'h010A);
    step();
    chk("stream_tail1", 32'(outResult), 32'h010B);
    step();
    outReady = 1'b0;
    chk("stream_empty", 32'(count), 32'd0);

    // Full with simultaneous pop and offered push
    for (int i = 0; i < 4; i++) pushOne(2'd2, 16'(16'h0200 + i), 4'h0, 3'b100);
    inValid = 1'b1; inResult = 16'h0204; outReady = 1'b1;
    chk("fullpop_inReady", 32'(inReady), 32'd0);
    step();
    outReady = 1'b0;
    chk("fullpop_count", 32'(count), 32'd3);
    chk("fullpop_head", 32'(outResult), 32'h0201);
    chk("fullpop_inReady_after", 32'(inReady), 32'd1);
    step();
    inValid = 1'b0;
    chk("held_accept_count", 32'(count), 32'd4);
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fullpop_drain_%0d", i), 32'(outResult), 32'(16'h0201 + i));
      step();
    end
    outReady = 1'b0;
    chk("fullpop_drained", 32'(count), 32'd0);

    // Sticky condition codes
    pushOne(2'd0, 16'h1111, 4'h1, 3'b000);
    pushOne(2'd0, 16'h2222, 4'h4, 3'b000);
    chk("sticky_or", 32'(stickyCondCodes), 32'h5);
    clearSticky = 1'b1;
    pushOne(2'd0, 16'h3333, 4'h8, 3'b000);
    clearSticky = 1'b0;
    chk("sticky_clear_push", 32'(stickyCondCodes), 32'h8);
    chk("sticky_head_cc", 32'(outCondCodes), 32'h1);
    clearSticky = 1'b1;
    step();
    clearSticky = 1'b0;
    chk("sticky_clear_only", 32'(stickyCondCodes), 32'h0);
    chk("sticky_count", 32'(count), 32'd3);
    inValid = 1'b1; inResult = 16'h4444; inCondCodes = 4'h2; outReady = 1'b1;
    step();
    inValid = 1'b0; outReady = 1'b0;
    chk("pre_reset_count", 32'(count), 32'd3);
    chk("pre_reset_sticky", 32'(stickyCondCodes), 32'h2);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk("async_outValid", 32'(outValid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_sticky", 32'(stickyCondCodes), 32'd0);
    chk("async_inReady", 32'(inReady), 32'd1);
    chk("async_outResult", 32'(outResult), 32'd0);
    #2;
    reset = 1'b0;
    pushOne(2'd3, 16'h5555, 4'h0, 3'b000);
    pushOne(2'd3, 16'h6666, 4'h0, 3'b000);
    chk("post_reset_count", 32'(count), 32'd2);
    outReady = 1'b1;
    chk("post_reset_first", 32'(outResult), 32'h5555);
    step();
    chk("post_reset_second", 32'(outResult), 32'h6666);
    step();
    outReady = 1'b0;
    chk("post_reset_empty", 32'(outValid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu16_result_fifo.md
# fpu16_result_fifo

Result buffer directly downstream of the FP16 FPU core. Captures each FPU result (value, condition codes, comparison flags, and the op that produced it) on a valid/ready handshake into a small circular FIFO. Presents results in order to the writeback consumer. Keeps sticky condition-code flags for software exception polling. Decouples the purely combinational FPU from a consumer that may stall.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clock  in  1  system clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- inValid  in  1  producer offers a result this cycle.
- inReady  out  1  FIFO can accept; equals !full.
- inOp  in  2  fpuOp_t of the result (ADD/SUB/MUL/DIV).
- inResult  in  16  fp16_t FPU result.
- inCondCodes  in  4  condCode_t produced with the result.
- inComps  in  3  fpuComp_t {lt, eq, gt}.
- outValid  out  1  head entry available; equals !empty.
- outReady  in  1  consumer takes head this cycle.
- outOp, outResult, outCondCodes, outComps  out  2/16/4/3  head entry fields; all zero when outValid=0.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- clearSticky  in  1  clear sticky flags.
- stickyCondCodes  out  4  OR of inCondCodes over all accepted pushes since the last reset or clear.

## Operation
- Entry = {op, result, condCodes, comps}, 25 bits. Storage is a register array of DEPTH entries; it is not reset.
- Pointers:
  - Write pointer wp and read pointer rp are log2(DEPTH) bits and wrap modulo DEPTH.
  - count tracks occupancy.
  - full = (count==DEPTH); empty = (count==0).
- Push = inValid & inReady: write entry at wp, then wp+1.
- Pop = outValid & outReady: rp+1.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - both: unchanged.
- Full: inReady=0 even if a pop occurs in the same cycle (no full-pop passthrough). inValid while full is ignored; the producer must hold its data.
- Empty: no input-to-output bypass. outValid=0 and out fields are 0. outReady is ignored.
- Ordering is strictly FIFO. Entries are never dropped or duplicated.
- Sticky flags:
  - next = (clearSticky ? 0 : sticky) | (push ? inCondCodes : 0).
  - When clear and push happen in the same cycle, the result is the pushed codes only.
- No state machine beyond the pointer/count datapath. States are implicitly EMPTY, PARTIAL and FULL, determined by count.

## Timing
- Reset (async assert, any cycle, including mid-transfer) clears the following immediately:
  - wp, rp and count to 0.
  - stickyCondCodes to 0.
  - outValid to 0, inReady to 1, and all out fields to 0.
- Reset release is sampled synchronously. The first push can occur on the first rising edge with reset=0.
- Latency from push to outValid: 1 cycle. An entry pushed at edge N is visible from N+ (combinational read of the head).
- inReady, outValid, count and stickyCondCodes are functions of registered state only. There is no combinational path from inValid or outReady to any output.
- Throughput: one push and one pop per cycle, sustained, when 0 < count < DEPTH.
- Pointer wrap: after DEPTH pushes wp returns to 0, and ordering is preserved across the wrap.

## Test plan
- Reset then single push of {ADD, 0x4200, cc=0x0, comps=3'b001}:
  - next cycle outValid=1, outResult=0x4200, count=1.
  - pop with outReady=1, then outValid=0 and out fields all zero.
- Fill DEPTH=4 with results 0x3C00, 0x4000, 0x4200, 0x4400 while outReady=0:
  - inReady=0 at count=4.
  - a fifth offer of 0x4500 is not accepted.
  - draining returns exactly 0x3C00, 0x4000, 0x4200, 0x4400 in order.
- Simultaneous push/pop at count=2 for 10 cycles with incrementing results:
  - count stays 2, and outputs appear in push order across two pointer wraps.
- Full with outReady=1 and inValid=1 in the same cycle:
  - pop occurs, push does not, and count goes 4→3.
  - next cycle inReady=1 and the held input is accepted.
- Sticky flags:
  - pushes with cc 0x1 then 0x4 give stickyCondCodes=0x5.
  - clearSticky together with a push of cc 0x8 gives 0x8.
  - clearSticky alone gives 0x0.
- Async reset asserted mid-cycle at count=3: outValid, count and sticky go to 0 before the next edge. After release, the first pushed value is the first value popped.
